// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type and width helpers for the systolic multiplier
// Contents: state_t (IDLE/LOAD/DRAIN/OUT), clog2(), accw() accumulator width derivation.
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Worst-case sum of K full-width products never overflows this width.
    function automatic int accw(input int dw, input int k);
        return 2 * dw + clog2(k);
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one processing element, registered operand pass-through plus multiply-accumulate
// Ports: CLK, RSTn (async active-low), clr (sync accumulator clear),
//        a_in/b_in operands in, a_out/b_out registered operands out (east/south), acc result.
module systolic_pe #(
    parameter int DATAWIDTH = 8,
    parameter int ACCW      = 18,
    parameter bit SIGNED    = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 clr,
    input  logic [DATAWIDTH-1:0] a_in,
    input  logic [DATAWIDTH-1:0] b_in,
    output logic [DATAWIDTH-1:0] a_out,
    output logic [DATAWIDTH-1:0] b_out,
    output logic [ACCW-1:0]      acc
);

    logic [ACCW-1:0] prod;

    // Operands are widened to ACCW before multiplying so the extension matches SIGNED.
    if (SIGNED) begin : g_s
        assign prod = ACCW'($signed(a_in)) * ACCW'($signed(b_in));
    end else begin : g_u
        assign prod = ACCW'(a_in) * ACCW'(b_in);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= clr ? '0 : acc + prod;
        end
    end

endmodule

// File: rtl/systolic_array_mm.sv
// systolic_array_mm: output-stationary NxN systolic multiplier C = A*B with streamed row output
// Ports: CLK, RSTn (async active-low); in_valid/in_ready with a_col (A column k) and b_row (B row k);
//        out_valid/out_ready with out_row (row r of C), out_last on row N-1; busy when not IDLE.
module systolic_array_mm
    import systolic_pkg::*;
#(
    parameter int N         = 3,
    parameter int K         = 3,
    parameter int DATAWIDTH = 8,
    parameter bit SIGNED    = 1'b0,
    localparam int ACCW     = accw(DATAWIDTH, K)
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*DATAWIDTH-1:0] a_col,
    input  logic [N*DATAWIDTH-1:0] b_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*ACCW-1:0]      out_row,
    output logic                   out_last,
    output logic                   busy
);

    localparam int CW = clog2(K + 2 * N) + 1;
    localparam int RW = clog2(N);

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [RW-1:0]       row, row_n;
    logic [N*ACCW-1:0]   out_row_n;
    logic                ld, take, clr;
    logic [DATAWIDTH-1:0] a_sk [N][N];
    logic [DATAWIDTH-1:0] b_sk [N][N];
    logic [DATAWIDTH-1:0] a_h  [N][N+1];
    logic [DATAWIDTH-1:0] b_v  [N+1][N];
    logic [ACCW-1:0]      acc  [N][N];

    assign in_ready  = state == IDLE || state == LOAD;
    assign take      = in_valid && in_ready;
    assign clr       = take && state == IDLE;
    assign busy      = state != IDLE;
    assign out_valid = state == OUT;
    assign out_last  = out_valid && row == RW'(N - 1);

    // Stage 0 captures the accepted beat (zeros otherwise, so gaps become aligned bubbles);
    // row/column i then sees i further delay stages.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            a_sk <= '{default: '0};
            b_sk <= '{default: '0};
        end else begin
            for (int i = 0; i < N; i++) begin
                a_sk[i][0] <= take ? a_col[i*DATAWIDTH +: DATAWIDTH] : '0;
                b_sk[i][0] <= take ? b_row[i*DATAWIDTH +: DATAWIDTH] : '0;
                for (int d = 1; d <= i; d++) begin
                    a_sk[i][d] <= a_sk[i][d-1];
                    b_sk[i][d] <= b_sk[i][d-1];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_edge
        assign a_h[i][0] = a_sk[i][i];
        assign b_v[0][i] = b_sk[i][i];
    end

    for (genvar i = 0; i < N; i++) begin : g_r
        for (genvar j = 0; j < N; j++) begin : g_c
            systolic_pe #(
                .DATAWIDTH(DATAWIDTH),
                .ACCW     (ACCW),
                .SIGNED   (SIGNED)
            ) u_pe (
                .CLK  (CLK),
                .RSTn (RSTn),
                .clr  (clr),
                .a_in (a_h[i][j]),
                .b_in (b_v[i][j]),
                .a_out(a_h[i][j+1]),
                .b_out(b_v[i+1][j]),
                .acc  (acc[i][j])
            );
        end
    end

    // DRAIN spans 2N edges so the last accumulate (PE(N-1,N-1)) has landed before row 0 loads.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        row_n   = row;
        ld      = 1'b0;
        case (state)
            IDLE: if (take) begin
                state_n = (K == 1) ? DRAIN : LOAD;
                cnt_n   = (K == 1) ? '0 : CW'(1);
            end
            LOAD: if (take) begin
                state_n = cnt == CW'(K - 1) ? DRAIN : LOAD;
                cnt_n   = cnt == CW'(K - 1) ? '0 : cnt + 1'b1;
            end
            DRAIN: begin
                state_n = cnt == CW'(2 * N - 1) ? OUT : DRAIN;
                cnt_n   = cnt + 1'b1;
                ld      = cnt == CW'(2 * N - 1);
                row_n   = '0;
            end
            OUT: if (out_ready) begin
                state_n = row == RW'(N - 1) ? IDLE : OUT;
                row_n   = row + 1'b1;
                ld      = row != RW'(N - 1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Row register holds through stalls and is zero outside OUT.
    always_comb begin
        out_row_n = (state_n == OUT) ? out_row : '0;
        if (ld)
            for (int j = 0; j < N; j++)
                out_row_n[j*ACCW +: ACCW] = acc[row_n][j];
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            cnt     <= '0;
            row     <= '0;
            out_row <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            row     <= row_n;
            out_row <= out_row_n;
        end
    end

endmodule

// File: tb/tb_systolic_array_mm.sv
// tb_systolic_array_mm: directed + random checks of unsigned and signed multipliers against a matrix model
module tb_systolic_array_mm;

    localparam int N    = 3;
    localparam int K    = 3;
    localparam int DW   = 8;
    localparam int ACCW = 2 * DW + $clog2(K);

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [N*DW-1:0] a_col = '0;
    logic [N*DW-1:0] b_row = '0;
    logic in_ready_u, out_valid_u, out_last_u, busy_u;
    logic in_ready_s, out_valid_s, out_last_s, busy_s;
    logic [N*ACCW-1:0] out_row_u, out_row_s;

    logic [DW-1:0] ma [N][K];
    logic [DW-1:0] mb [K][N];
    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    systolic_array_mm #(.N(N), .K(K), .DATAWIDTH(DW), .SIGNED(1'b0)) u_dut_u (
        .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready_u),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_row(out_row_u), .out_last(out_last_u), .busy(busy_u)
    );

    systolic_array_mm #(.N(N), .K(K), .DATAWIDTH(DW), .SIGNED(1'b1)) u_dut_s (
        .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready_s),
        .a_col(a_col), .b_row(b_row), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_row(out_row_s), .out_last(out_last_s), .busy(busy_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain dot products of row r of A with each column of B.
    function automatic logic [N*ACCW-1:0] exp_row(input int r, input bit sg);
        logic [N*ACCW-1:0] res;
        int s;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < K; k++)
                if (sg) s += int'($signed(ma[r][k])) * int'($signed(mb[k][j]));
                else    s += int'(ma[r][k]) * int'(mb[k][j]);
            res[j*ACCW +: ACCW] = ACCW'(s);
        end
        return res;
    endfunction

    task automatic fill_seq(input bit b_ident);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                ma[i][k] = DW'(i * K + k + 1);
                if (b_ident) mb[k][i] = (k == i) ? DW'(1) : DW'(0);
                else         mb[k][i] = DW'(k * N + i + 1);
            end
    endtask

    task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                ma[i][k] = av;
                mb[k][i] = bv;
            end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                ma[i][k] = DW'($urandom);
                mb[k][i] = DW'($urandom);
            end
    endtask

    // Called at a negedge; returns at the negedge after the last beat's accept edge.
    task automatic send(input int gap);
        for (int k = 0; k < K; k++) begin
            int t = 0;
            in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                a_col[i*DW +: DW] = ma[i][k];
                b_row[i*DW +: DW] = mb[k][i];
            end
            while (!in_ready_u && t < 50) begin
                @(negedge CLK);
                t++;
            end
            chk("in_ready_beat", in_ready_u, 1);
            @(negedge CLK);
            in_valid = 1'b0;
            a_col = (N*DW)'($urandom);
            b_row = (N*DW)'($urandom);
            if (k < K - 1) repeat (gap) @(negedge CLK);
        end
    endtask

    task automatic wait_out();
        int lat = 0;
        chk("in_ready_drain", in_ready_u, 0);
        chk("busy_drain", busy_u, 1);
        while (!out_valid_u && lat < 100) begin
            chk("row_zero_invalid", out_row_u, 0);
            @(negedge CLK);
            lat++;
        end
        chk("latency", lat, 2 * N);
        chk("valid_s", out_valid_s, 1);
    endtask

    task automatic recv(input logic [3:0] pat);
        int r = 0;
        int t = 0;
        while (r < N && t < 200) begin
            out_ready = pat[t % 4];
            chk("valid_u", out_valid_u, 1);
            chk($sformatf("row%0d_u", r), out_row_u, exp_row(r, 1'b0));
            chk($sformatf("row%0d_s", r), out_row_s, exp_row(r, 1'b1));
            chk("last", out_last_u, r == N - 1);
            if (out_ready) r++;
            @(negedge CLK);
            t++;
        end
        out_ready = 1'b0;
        chk("rows_done", r, N);
        chk("post_valid", out_valid_u, 0);
        chk("post_row", out_row_u, 0);
        chk("post_last", out_last_u, 0);
        chk("post_in_ready", in_ready_u, 1);
    endtask

    task automatic run(input int gap, input logic [3:0] pat);
        send(gap);
        wait_out();
        recv(pat);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_valid", out_valid_u, 0);
        chk("rst_row", out_row_u, 0);
        chk("rst_last", out_last_u, 0);
        chk("rst_busy", busy_u, 0);
        chk("rst_in_ready", in_ready_u, 1);
        chk("rst_row_s", out_row_s, 0);
        RSTn = 1'b1;
        @(negedge CLK);

        fill_seq(1'b1);
        run(0, 4'hF);
        fill_seq(1'b0);
        run(0, 4'hF);
        fill_const(8'hFF, 8'hFF);
        run(0, 4'hF);
        fill_const(8'h80, 8'h80);
        run(0, 4'hF);
        fill_const(8'h80, 8'h7F);
        run(0, 4'hF);
        fill_seq(1'b0);
        run(2, 4'b1001);

        fill_rand();
        run(0, 4'hF);
        fill_rand();
        run(0, 4'hF);
        repeat (6) begin
            fill_rand();
            run(int'($urandom_range(0, 2)), 4'($urandom) | 4'b0001);
        end

        fill_rand();
        send(0);
        @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        chk("midrst_valid", out_valid_u, 0);
        chk("midrst_row", out_row_u, 0);
        chk("midrst_last", out_last_u, 0);
        chk("midrst_busy", busy_u, 0);
        chk("midrst_busy_s", busy_s, 0);
        chk("midrst_in_ready", in_ready_u, 1);
        RSTn = 1'b1;
        @(negedge CLK);
        fill_seq(1'b1);
        run(0, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
